// File: rtl/chess_clock_timer_if.sv
// Purpose: one player's control/display bundle between the game FSM and its countdown timer.
// Latency: none, wires only.
// Backpressure: none; level signals sampled every i_clk cycle.
// Signals: i_restart, i_stop (FSM -> timer); o_min, o_sec, o_zero, o_running (timer -> FSM).
// Modports: master = game FSM side, slave = timer side.
interface chess_clock_timer_if;
   logic       i_restart;
   logic       i_stop;
   logic [6:0] o_min;
   logic [5:0] o_sec;
   logic       o_zero;
   logic       o_running;

   modport master (
      output i_restart,
      output i_stop,
      input  o_min,
      input  o_sec,
      input  o_zero,
      input  o_running
   );

   modport slave (
      input  i_restart,
      input  i_stop,
      output o_min,
      output o_sec,
      output o_zero,
      output o_running
   );
endinterface

// File: rtl/chess_clock_timer.sv
// Purpose: per-player chess clock; MM:SS countdown with per-move increment, HOLD/RUN/EXPIRED FSM.
// Latency: all outputs registered; i_stop 1->0 shows o_running=1 one cycle later, first tick CLK_HZ RUN cycles after prescaler 0.
// Backpressure: none; i_restart and i_stop are levels sampled every cycle.
// Ports: i_clk, i_rst (sync, active-high); bus.i_restart reloads INIT_SEC, bus.i_stop holds/runs,
//        bus.o_min/o_sec remaining time, bus.o_zero time expired, bus.o_running in RUN state.
module chess_clock_timer #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int INIT_SEC = 300,
   parameter int INC_SEC  = 0
) (
   input  logic                i_clk,
   input  logic                i_rst,
   chess_clock_timer_if.slave  bus
);

   localparam int              PW        = $clog2(CLK_HZ);
   localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [6:0]      INIT_MIN  = 7'(INIT_SEC / 60);
   localparam logic [5:0]      INIT_S    = 6'(INIT_SEC % 60);
   localparam logic            INIT_ZERO = (INIT_SEC == 0);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'b00,
      ST_RUN     = 2'b01,
      ST_EXPIRED = 2'b10
   } state_t;

   // Declaration values make power-up state identical to the reset state.
   state_t         state_q     = ST_HOLD;
   logic [6:0]     min_q       = INIT_MIN;
   logic [5:0]     sec_q       = INIT_S;
   logic [PW-1:0]  presc_q     = '0;
   logic           prev_stop_q = 1'b1;
   logic           zero_q      = INIT_ZERO;
   logic           running_q   = 1'b0;

   state_t         state_d;
   logic [6:0]     min_d;
   logic [5:0]     sec_d;
   logic [PW-1:0]  presc_d;
   logic           prev_stop_d;
   logic           zero_d;
   logic           running_d;
   logic           reload;

   logic           time_zero;
   logic           run_go;
   logic           tick;
   logic           stop_edge;
   logic           inc_go;
   logic [6:0]     sec_sum;
   logic [7:0]     min_inc;

   assign time_zero = (min_q == 7'd0) && (sec_q == 6'd0);
   assign run_go    = (state_q == ST_RUN) && !bus.i_stop;
   assign tick      = run_go && (presc_q == PRESC_MAX);
   // Only a RUN-state falling-to-stop transition earns the increment; an
   // expired clock never reaches RUN, so it can never gain time back.
   assign stop_edge = (state_q == ST_RUN) && bus.i_stop && !prev_stop_q;
   assign inc_go    = stop_edge && !time_zero;
   assign sec_sum   = {1'b0, sec_q} + 7'(INC_SEC);
   assign min_inc   = {1'b0, min_q} + 8'd1;

   // ---------------- state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= ST_HOLD;
      else       state_q <= state_d;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      reload  = 1'b0;
      case (state_q)
         ST_HOLD: begin
            if (time_zero)         state_d = ST_EXPIRED;
            else if (!bus.i_stop)  state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.i_stop)        state_d = ST_HOLD;
            // The tick that consumes the final second expires the clock.
            else if (tick && (min_q == 7'd0) && (sec_q == 6'd1))
                                   state_d = ST_EXPIRED;
         end
         ST_EXPIRED: state_d = ST_EXPIRED;
         default: begin
            state_d = ST_HOLD;
            reload  = 1'b1;
         end
      endcase
      if (bus.i_restart) begin
         state_d = ST_HOLD;
         reload  = 1'b1;
      end
   end

   // ---------------- time / prescaler next values ----------------
   always_comb begin
      min_d       = min_q;
      sec_d       = sec_q;
      presc_d     = presc_q;
      prev_stop_d = bus.i_stop;
      if (reload) begin
         min_d       = INIT_MIN;
         sec_d       = INIT_S;
         presc_d     = '0;
         prev_stop_d = 1'b1;
      end else begin
         // Prescaler is frozen outside RUN so the sub-second remainder
         // carries into the player's next turn.
         if (run_go) presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            if (sec_q != 6'd0) begin
               sec_d = sec_q - 6'd1;
            end else if (min_q != 7'd0) begin
               sec_d = 6'd59;
               min_d = min_q - 7'd1;
            end
         end
         // tick requires i_stop=0 and inc_go requires i_stop=1: never both.
         if (inc_go) begin
            if (sec_sum < 7'd60) begin
               sec_d = sec_sum[5:0];
            end else if (min_q >= 7'd99) begin
               min_d = 7'd99;
               sec_d = 6'd59;
            end else begin
               min_d = min_inc[6:0];
               sec_d = 6'(sec_sum - 7'd60);
            end
         end
      end
   end

   // ---------------- output logic (registered below) ----------------
   always_comb begin
      zero_d    = (min_d == 7'd0) && (sec_d == 6'd0);
      running_d = (state_d == ST_RUN);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         min_q       <= INIT_MIN;
         sec_q       <= INIT_S;
         presc_q     <= '0;
         prev_stop_q <= 1'b1;
         zero_q      <= INIT_ZERO;
         running_q   <= 1'b0;
      end else begin
         min_q       <= min_d;
         sec_q       <= sec_d;
         presc_q     <= presc_d;
         prev_stop_q <= prev_stop_d;
         zero_q      <= zero_d;
         running_q   <= running_d;
      end
   end

   assign bus.o_min     = min_q;
   assign bus.o_sec     = sec_q;
   assign bus.o_zero    = zero_q;
   assign bus.o_running = running_q;

endmodule

// File: doc/chess_clock_timer.md
CHESS_CLOCK_TIMER -- requirements
Module: chess_clock_timer

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, i_clk cycles per one-second tick; legal range 2..2^27.
REQ-002 Parameter INIT_SEC, default 300, initial time in seconds; legal range 0..5999.
REQ-003 Parameter INC_SEC, default 0, per-move increment in seconds; legal range 0..59.
REQ-004 i_clk  in  1  single clock; all logic on posedge.
REQ-005 i_rst  in  1  reset, synchronous, active-high.
REQ-006 i_restart  in  1  reload INIT_SEC; driven by FSM o_restart.
REQ-007 i_stop  in  1  1 = hold, 0 = count down; driven by FSM o_player_x_stop.
REQ-008 o_min  out  7  remaining minutes, 0..99, registered.
REQ-009 o_sec  out  6  remaining seconds, 0..59, registered.
REQ-010 o_zero  out  1  time expired; feeds FSM i_player_x_zero; registered.
REQ-011 o_running  out  1  1 while in RUN state; registered.

Function
REQ-012 States: HOLD, RUN, EXPIRED; 2-bit encoding; unused encodings -> HOLD with time reload.
REQ-013 Priority per cycle: i_rst > i_restart > state update.
REQ-014 HOLD -> RUN when i_stop=0 and time != 00:00; HOLD -> EXPIRED when time = 00:00.
REQ-015 RUN -> HOLD when i_stop=1; RUN -> EXPIRED on tick that makes time 00:00.
REQ-016 EXPIRED held until i_rst or i_restart; i_stop ignored.
REQ-017 Prescaler counts 0..CLK_HZ-1 only in RUN with i_stop=0; wraps to 0 and issues one tick at CLK_HZ-1.
REQ-018 Prescaler holds (not cleared) in HOLD; sub-second remainder carried to next turn.
REQ-019 Tick: sec>0 -> sec-1; sec=0 and min>0 -> sec=59, min-1; time never goes below 00:00.
REQ-020 o_zero asserts in same cycle time registers show 00:00; stays 1 in EXPIRED.
REQ-021 Stop edge = i_stop=1 and registered previous i_stop=0, detected only while in RUN.
REQ-022 On stop edge, time += INC_SEC with seconds carry into minutes; saturate at 99:59.
REQ-023 Stop edge and tick are mutually exclusive (tick needs i_stop=0); no combined case.
REQ-024 No increment when stop edge coincides with time 00:00 or state EXPIRED.
REQ-025 i_restart: min=INIT_SEC/60, sec=INIT_SEC%60, prescaler=0, prev-stop=1, state=HOLD, o_zero=(INIT_SEC==0), o_running=0; takes effect next cycle; overrides tick and increment in same cycle.
REQ-026 Restart held high keeps block in reload; counting resumes cycle after release.
REQ-027 Latency: i_stop 1->0 to o_running=1 is 1 cycle; first tick CLK_HZ cycles after prescaler start from 0.

Reset
REQ-028 i_rst yields identical register values to REQ-025 on next posedge; no asynchronous path.
REQ-029 Power-up initial values equal reset values.
REQ-030 Reset mid-count discards prescaler remainder and any pending increment.

Verification (CLK_HZ=4, INIT_SEC=62, INC_SEC=3 unless stated)
REQ-031 Reset, i_stop=0 for 8 cycles -> o_min=1, o_sec=0 after 2nd tick; o_running=1 from cycle 1.
REQ-032 Run to 01:00 then one more tick -> o_min=0, o_sec=59 (borrow).
REQ-033 Run 2 cycles into a second, i_stop=1 for 10 cycles, i_stop=0 -> increment +3 s applied once; next tick after 2 more RUN cycles (prescaler held).
REQ-034 INIT_SEC=1, i_stop=0 -> after 4 cycles o_min=0, o_sec=0, o_zero=1; later i_stop toggles -> no increment, stays EXPIRED.
REQ-035 INIT_SEC=5998, INC_SEC=3, one stop edge -> o_min=99, o_sec=59 (saturated).
REQ-036 i_restart asserted on tick cycle -> next cycle 01:02, o_zero=0, o_running=0; no tick applied.
